incr_rr_scheduler: RTL and testbench

//  Shares one WIDTH-bit incrementer among N_REQ requesters.

---
 rtl/incr_pkg.sv | 12 +
 rtl/incr_core.sv | 14 +
 rtl/incr_rr_scheduler.sv | 104 ++++++++++
 tb/tb_incr_rr_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/incr_pkg.sv
// Shared types and defaults for the round-robin incrementer scheduler.
package incr_pkg;
  localparam int INCR_WIDTH = 4;
  localparam int INCR_N_REQ = 4;

  typedef logic [INCR_WIDTH-1:0] incr_word_t;

  typedef struct packed {
    incr_word_t data;
    logic       carry;
  } incr_result_t;
endpackage

// File: rtl/incr_core.sv
// Combinational shared incrementer: {carry, result} = operand + 1.
module incr_core
  import incr_pkg::*;
#(
  parameter int WIDTH = INCR_WIDTH
) (
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  assign {carry, result} = {1'b0, operand} + (WIDTH+1)'(1);

endmodule

// File: rtl/incr_rr_scheduler.sv
// Round-robin sharing of one incrementer among N_REQ requesters, registered response.
// Optional saturating overflow counter enabled by macro INCR_OVF_CNT_EN.
module incr_rr_scheduler
  import incr_pkg::*;
#(
  parameter  int N_REQ = INCR_N_REQ,
  parameter  int WIDTH = INCR_WIDTH,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_carry,
  output logic [ID_W-1:0]    rsp_id
`ifdef INCR_OVF_CNT_EN
  ,
  output logic [7:0]         ovf_count
`endif
);

  logic [ID_W-1:0]  rr_ptr;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] operand_p0;
  logic [WIDTH-1:0] sum_p0;
  logic             carry_p0;
  logic [ID_W-1:0]  ptr_next;

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;
  logic             carry_p1;
  logic [ID_W-1:0]  id_p1;

  // Stage p0: arbitration and shared increment. Scanning downward lets the
  // lowest offset from rr_ptr overwrite any later candidate.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  assign can_accept = !vld_p1 || rsp_ready;
  assign accept     = rst_n && can_accept && grant_found;
  assign req_ready  = accept ? (N_REQ'(1) << grant_idx) : '0;
  assign operand_p0 = req_data[int'(grant_idx)*WIDTH +: WIDTH];
  assign ptr_next   = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  incr_core #(.WIDTH(WIDTH)) u_core (
    .operand (operand_p0),
    .result  (sum_p0),
    .carry   (carry_p0)
  );

  // Stage p1: one-entry response register; held while backpressured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      carry_p1 <= 1'b0;
      id_p1    <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      data_p1  <= sum_p0;
      carry_p1 <= carry_p0;
      id_p1    <= grant_idx;
      rr_ptr   <= ptr_next;
    end else if (rsp_ready) begin
      vld_p1   <= 1'b0;
    end
  end

  assign rsp_valid = vld_p1;
  assign rsp_data  = data_p1;
  assign rsp_carry = carry_p1;
  assign rsp_id    = id_p1;

`ifdef INCR_OVF_CNT_EN
  logic [7:0] ovf_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_p1 <= '0;
    end else if (accept && carry_p0 && (ovf_p1 != 8'hFF)) begin
      ovf_p1 <= ovf_p1 + 8'd1;
    end
  end

  assign ovf_count = ovf_p1;
`endif

endmodule

// File: tb/tb_incr_rr_scheduler.sv
// Directed self-checking bench for incr_rr_scheduler (default N_REQ=4, WIDTH=4).
// Exercises the INCR_OVF_CNT_EN counter when that macro is defined.
module tb_incr_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_data;
  logic        rsp_carry;
  logic [1:0]  rsp_id;
`ifdef INCR_OVF_CNT_EN
  logic [7:0]  ovf_count;
`endif

  int n_checks;
  int n_fail;

  incr_rr_scheduler #(.N_REQ(4), .WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id)
`ifdef INCR_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [3:0] d,
                           input logic c, input logic [1:0] id);
    check({tag, "_valid"}, 32'(rsp_valid), 32'(v));
    check({tag, "_data"},  32'(rsp_data),  32'(d));
    check({tag, "_carry"}, 32'(rsp_carry), 32'(c));
    check({tag, "_id"},    32'(rsp_id),    32'(id));
  endtask

  logic [3:0] fair_exp_data [4];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 16'h0000;
    rsp_ready = 1'b1;

    // Reset with all requesters active
    #1;
    check("rst_ready_comb", 32'(req_ready), 32'h0);
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 32'h0);
    check_rsp("rst", 1'b0, 4'h0, 1'b0, 2'd0);
`ifdef INCR_OVF_CNT_EN
    check("rst_ovf", 32'(ovf_count), 32'h0);
`endif

    rst_n = 1'b1;
    #1;
    check("first_grant", 32'(req_ready), 32'h1);
    req_valid = 4'b0000;
    tick();
    check("idle_no_rsp", 32'(rsp_valid), 32'h0);

    // Single request on requester 0
    req_valid = 4'b0001;
    req_data  = {4'h0, 4'h0, 4'h0, 4'b0101};
    #1;
    check("single_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0000;
    check_rsp("single", 1'b1, 4'b0110, 1'b0, 2'd0);
    tick();
    check("drain_valid", 32'(rsp_valid), 32'h0);

    // Wrap on requester 2 (pointer now at 1)
    req_valid = 4'b0100;
    req_data  = {4'h0, 4'hF, 4'h0, 4'h0};
    #1;
    check("wrap_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    check_rsp("wrap", 1'b1, 4'h0, 1'b1, 2'd2);
`ifdef INCR_OVF_CNT_EN
    check("wrap_ovf", 32'(ovf_count), 32'h1);
`endif
    tick();

    // Reset pointer, then fairness across all four requesters
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_data  = {4'hE, 4'h3, 4'h2, 4'h1};
    fair_exp_data[0] = 4'h2;
    fair_exp_data[1] = 4'h3;
    fair_exp_data[2] = 4'h4;
    fair_exp_data[3] = 4'hF;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("fair_grant%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      check_rsp($sformatf("fair%0d", k), 1'b1, fair_exp_data[k % 4], 1'b0, 2'(k % 4));
    end
    req_valid = 4'b0000;

    // Backpressure: response from requester 3 must hold
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    req_data  = {4'h0, 4'h7, 4'h0, 4'h0};
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_ready%0d", k), 32'(req_ready), 32'h0);
      tick();
      check_rsp($sformatf("bp%0d", k), 1'b1, 4'hF, 1'b0, 2'd3);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0000;
    check_rsp("bp_release", 1'b1, 4'h8, 1'b0, 2'd2);

    // Mid-operation reset discards the held response
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    rst_n     = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready), 32'h0);
    tick();
    check_rsp("midrst", 1'b0, 4'h0, 1'b0, 2'd0);
    rst_n     = 1'b1;
    req_valid = 4'b0000;
    rsp_ready = 1'b1;
    tick();

`ifdef INCR_OVF_CNT_EN
    // Saturation: 300 carry-producing transfers
    req_data  = 16'hFFFF;
    req_valid = 4'b1111;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (k == 9) check("sat_mid_ovf", 32'(ovf_count), 32'd10);
    end
    req_valid = 4'b0000;
    tick();
    check("sat_ovf", 32'(ovf_count), 32'hFF);
    check("sat_carry", 32'(rsp_carry), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
